// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN             - architectural register / address width
//   DEFAULT_RESET_PC - PC the core starts from unless overridden
//   PC_INC           - sequential fetch stride (one 32-bit instruction)
//   state_t          - fetch sequencer state encoding (2-bit)
//   is_aligned()     - true when an address is on a 4-byte boundary
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding (or about to be raised) at pc
    HOLD  = 2'd1,  // instruction presented to decode, waiting for hand-off
    FLUSH = 2'd2,  // wrong-path kill window after a redirect
    TRAP  = 2'd3   // misaligned target seen; parked until reset
  } state_t;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC and sequences instruction fetch for a
// single-issue core: one req/ack read at a time, one instruction held for
// decode at a time, redirects applied with a timed flush, misaligned
// targets trapped.
//
// Ports:
//   clk, reset                 - rising-edge clock, synchronous active-high reset
//   imem_req / imem_addr       - fetch request, held with a stable address until ack
//   imem_ack / imem_rdata      - read response, only honoured while imem_req is high
//   if_valid/if_instr/if_pc    - instruction presented to decode
//   id_ready, stall            - decode accepts when id_ready && !stall
//   redirect_valid/redirect_pc - taken branch/jump from the branch-resolution unit
//   flush_out                  - kill for decode/execute, FLUSH_CYCLES long
//   trap / trap_pc             - sticky misaligned-target trap and its target
//
// FLUSH_CYCLES must be >= 1; it covers the branch unit's registered latency.
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            flush_out,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc
);

  // Counter holds FLUSH_CYCLES-1 down to 0, so clog2(FLUSH_CYCLES) bits suffice.
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t            state_q,  state_d;
  logic [XLEN-1:0]   pc_q,     pc_d;
  logic              req_q,    req_d;
  logic              valid_q,  valid_d;
  logic [XLEN-1:0]   instr_q,  instr_d;
  logic [XLEN-1:0]   ifpc_q,   ifpc_d;
  logic              flush_q,  flush_d;
  logic              trap_q,   trap_d;
  logic [XLEN-1:0]   trap_pc_q, trap_pc_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  logic transfer;

  // Decode takes the held instruction this cycle.
  assign transfer = valid_q && id_ready && !stall;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every target gets a default before any branch, so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    ifpc_d    = ifpc_q;
    flush_d   = flush_q;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      FETCH: begin
        // Ack only counts while our request is actually on the bus; a late
        // ack for an abandoned request is ignored.
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_INC;  // wraps modulo 2^32
          req_d   = 1'b0;
          state_d = HOLD;
        end else begin
          req_d   = 1'b1;
        end
      end
      HOLD: begin
        if (transfer) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          flush_d = 1'b0;
          req_d   = 1'b1;
          state_d = FETCH;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      TRAP: begin
        // Parked: only reset leaves this state.
      end
      default: state_d = TRAP;
    endcase

    // A redirect overrides whatever the state logic chose, including a
    // coincident capture: the fetched word is dropped and the held
    // instruction registers keep their old contents.
    if (redirect_valid && (state_q != TRAP)) begin
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      valid_d = 1'b0;
      req_d   = 1'b0;
      if (is_aligned(redirect_pc)) begin
        pc_d    = redirect_pc;
        flush_d = 1'b1;
        cnt_d   = FLUSH_LOAD;
        state_d = FLUSH;
      end else begin
        pc_d      = pc_q;
        flush_d   = 1'b0;
        trap_d    = 1'b1;
        trap_pc_d = redirect_pc;
        state_d   = TRAP;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      ifpc_q    <= '0;
      flush_q   <= 1'b0;
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      ifpc_q    <= ifpc_d;
      flush_q   <= flush_d;
      trap_q    <= trap_d;
      trap_pc_q <= trap_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  // pc only changes on a capture or redirect, both of which drop the
  // request, so the registered pc doubles as a stable fetch address.
  assign imem_addr = pc_q;
  assign imem_req  = req_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;
  assign flush_out = flush_q;
  assign trap      = trap_q;
  assign trap_pc   = trap_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by a
// randomized run. A memory responder with configurable latency answers
// requests; a transaction-level model predicts which PC decode must see
// next (sequential +4, aligned redirects replace it, misaligned ones park
// the core until reset).
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_out;
  logic        trap;
  logic [31:0] trap_pc;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_out      (flush_out),
    .trap           (trap),
    .trap_pc        (trap_pc)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          transfers = 0;
  logic [31:0] exp_pc;
  bit          trapped;
  int          mem_cnt;
  int          mem_lat;
  logic [31:0] mem_addr;
  bit          mem_rand;
  bit          late_ack;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive the memory response for the current cycle,
  // update the model, then advance past the edge.
  task automatic tick();
    if (imem_req === 1'b1) begin
      if (mem_cnt == 0) mem_addr = imem_addr;
      else              check("addr_stable", imem_addr, mem_addr);
      imem_ack   = (mem_cnt >= mem_lat);
      imem_rdata = mem_word(mem_addr);
      mem_cnt++;
    end else begin
      imem_ack   = late_ack;
      imem_rdata = 32'hDEAD_BEEF;
      mem_cnt    = 0;
      mem_lat    = mem_rand ? int'($urandom_range(0, 3)) : 1;
    end

    if (reset) begin
      exp_pc  = RESET_PC;
      trapped = 1'b0;
    end else begin
      if (flush_out === 1'b1)
        check("flush_quiet", 32'({imem_req, if_valid}), 32'd0);
      if (if_valid === 1'b1 && id_ready && !stall) begin
        check("xfer_pc", if_pc, exp_pc);
        check("xfer_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        transfers++;
      end
      if (redirect_valid && !trapped) begin
        if (redirect_pc[1:0] == 2'b00) exp_pc  = redirect_pc;
        else                           trapped = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (if_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({"valid_", tag}, 32'(if_valid), 32'd1);
  endtask

  task automatic wait_flush(output int n);
    n = 0;
    while (flush_out === 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int n;
    int bad;
    logic [31:0] tgt;

    reset = 1'b1; id_ready = 1'b1; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    late_ack = 1'b0; mem_rand = 1'b0; mem_lat = 1; mem_cnt = 0;
    exp_pc = RESET_PC; trapped = 1'b0; prev = 0;

    // Reset state.
    tick(); tick();
    check("rst_req",     32'(imem_req),  32'd0);
    check("rst_addr",    imem_addr,      RESET_PC);
    check("rst_valid",   32'(if_valid),  32'd0);
    check("rst_instr",   if_instr,       32'd0);
    check("rst_ifpc",    if_pc,          32'd0);
    check("rst_flush",   32'(flush_out), 32'd0);
    check("rst_trap",    32'(trap),      32'd0);
    check("rst_trap_pc", trap_pc,        32'd0);

    // Sequential fetch: 0x0, 0x4, 0x8, one hand-off every 3 cycles.
    reset = 1'b0;
    tick();
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", imem_addr,      RESET_PC);
    for (int k = 0; k < 3; k++) begin
      wait_valid("seq");
      check("seq_ifpc", if_pc, 32'(k * 4));
      if (k > 0) check("seq_period", 32'(cyc - prev), 32'd3);
      prev = cyc;
      if (k < 2) begin
        tick();
        check("seq_req",  32'(imem_req), 32'd1);
        check("seq_addr", imem_addr,      32'((k + 1) * 4));
      end
    end

    // Stall held in HOLD at if_pc = 0x8.
    stall = 1'b1;
    repeat (5) begin
      tick();
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_ifpc",  if_pc,         32'h8);
      check("stall_instr", if_instr,      mem_word(32'h8));
      check("stall_req",   32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    check("unstall_req",   32'(imem_req), 32'd1);
    check("unstall_addr",  imem_addr,      32'hC);
    check("unstall_valid", 32'(if_valid), 32'd0);

    // Redirect to 0x100 in the same cycle as the ack for 0xC.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("rd_flush", 32'(flush_out), 32'd1);
    check("rd_req",   32'(imem_req),  32'd0);
    check("rd_valid", 32'(if_valid),  32'd0);
    wait_flush(n);
    check("rd_flush_len", 32'(n), 32'd2);
    check("rd_req_after",  32'(imem_req), 32'd1);
    check("rd_addr_after", imem_addr,     32'h100);
    wait_valid("rd");
    check("rd_ifpc",  if_pc,    32'h100);
    check("rd_instr", if_instr, mem_word(32'h100));

    // Misaligned target while 0x100 is also being handed off.
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    check("trap_set",   32'(trap),      32'd1);
    check("trap_pc",    trap_pc,        32'h102);
    check("trap_valid", 32'(if_valid),  32'd0);
    check("trap_flush", 32'(flush_out), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin redirect_valid = 1'b1; redirect_pc = 32'h200; end
      tick();
      redirect_valid = 1'b0;
      if (imem_req !== 1'b0 || if_valid !== 1'b0) bad++;
    end
    check("trap_quiet",  32'(bad),  32'd0);
    check("trap_sticky", 32'(trap), 32'd1);
    check("trap_pc_hold", trap_pc,  32'h102);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("trap_clr",    32'(trap),     32'd0);
    check("trap_pc_clr", trap_pc,       32'd0);
    tick();
    check("resume_req",  32'(imem_req), 32'd1);
    check("resume_addr", imem_addr,     RESET_PC);
    wait_valid("resume");
    check("resume_ifpc", if_pc, RESET_PC);

    // PC wrap from 0xFFFF_FFFC to 0.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_flush(n);
    wait_valid("wrap");
    check("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_req",  32'(imem_req), 32'd1);
    check("wrap_addr", imem_addr,     32'h0);
    check("wrap_trap", 32'(trap),     32'd0);
    wait_valid("wrap2");
    check("wrap_ifpc2", if_pc, 32'h0);

    // Reset mid-FETCH, then a stray ack while req is still low.
    tick();
    check("mid_req", 32'(imem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    check("late_req",   32'(imem_req), 32'd1);
    check("late_addr",  imem_addr,     RESET_PC);
    check("late_valid", 32'(if_valid), 32'd0);
    wait_valid("late");
    check("late_instr", if_instr, mem_word(RESET_PC));
    check("late_ifpc",  if_pc,    RESET_PC);

    // Randomized traffic against the model.
    mem_rand  = 1'b1;
    transfers = 0;
    for (int i = 0; i < 1500; i++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      tgt = $urandom();
      if ($urandom_range(0, 3) == 0) tgt = tgt | 32'hFFFF_FFE0;
      tgt[1:0] = 2'b00;
      redirect_pc = tgt;
      tick();
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    id_ready = 1'b1;
    repeat (10) tick();
    check("rand_progress", 32'(transfers >= 100), 32'd1);
    check("rand_no_trap",  32'(trap),             32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
